// File: rtl/dsp_run_pkg.sv
// dsp_run_pkg -- shared types and constants for the DSP run controller.
//   state_t    : controller FSM states
//   status_t   : 2-bit result status, with ST_PASS/ST_FAIL/ST_TIMEOUT/ST_ABORT
//   DEF_*      : default parameter values for dsp_run_ctrl and dsp_run_if
//   PH_W       : width of the reset/gap phase counter
package dsp_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_GAP,
        S_START,
        S_RUN,
        S_REPORT
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t ST_PASS    = 2'd0;
    localparam status_t ST_FAIL    = 2'd1;
    localparam status_t ST_TIMEOUT = 2'd2;
    localparam status_t ST_ABORT   = 2'd3;

    localparam int DEF_RST_CYC = 10;
    localparam int DEF_GAP_CYC = 2;
    localparam int DEF_TO_W    = 16;

    localparam int PH_W = 16;

endpackage

// File: rtl/dsp_run_if.sv
// dsp_run_if -- host-side bundle of the DSP run controller.
//   cmd_valid/cmd_ready   : run-command handshake
//   cmd_max_cyc           : watchdog limit in RUN cycles (TO_W bits)
//   cmd_exp_acc           : expected final accumulator value
//   abort                 : cancel the run in progress
//   res_valid/res_ready   : result handshake
//   res_status/acc/pc     : result status, captured accumulator and pc
//   res_cycles            : RUN cycle count (TO_W bits)
//   busy                  : controller not in IDLE
// Modports: master = host, slave = controller.
interface dsp_run_if
    import dsp_run_pkg::*;
#(
    parameter int TO_W = DEF_TO_W
) ();

    logic            cmd_valid;
    logic            cmd_ready;
    logic [TO_W-1:0] cmd_max_cyc;
    logic [31:0]     cmd_exp_acc;
    logic            abort;
    logic            res_valid;
    logic            res_ready;
    status_t         res_status;
    logic [31:0]     res_acc;
    logic [15:0]     res_pc;
    logic [TO_W-1:0] res_cycles;
    logic            busy;

    modport master (
        output cmd_valid, cmd_max_cyc, cmd_exp_acc, abort, res_ready,
        input  cmd_ready, res_valid, res_status, res_acc, res_pc, res_cycles, busy
    );

    modport slave (
        input  cmd_valid, cmd_max_cyc, cmd_exp_acc, abort, res_ready,
        output cmd_ready, res_valid, res_status, res_acc, res_pc, res_cycles, busy
    );

endinterface

// File: rtl/dsp_run_wdog.sv
// dsp_run_wdog -- saturating run-cycle counter used as the watchdog.
//   clk, rst  : clock, synchronous active-low reset
//   clr       : clear count to 0 (wins over en)
//   en        : increment count, holding at all-ones
//   limit     : watchdog limit
//   count     : current count
//   at_limit  : count == limit
module dsp_run_wdog #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic [TO_W-1:0] count,
    output logic            at_limit
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/dsp_run_ctrl.sv
// dsp_run_ctrl -- sequences one DSP core run: hold core reset, idle gap,
// start pulse, then watch for done/timeout/abort and report a result.
//   clk, rst         : clock, synchronous active-low reset
//   bus (slave)      : command/result handshakes, abort and busy
//   core_rst         : active-high core reset
//   core_start       : one-cycle start pulse to the core
//   core_done        : core finished (only sampled in RUN)
//   core_acc/core_pc : core accumulator and program counter
// Build option: DSP_RUN_CYCLE_COUNT_EN -- when defined, res_cycles reports
// the RUN cycle count; otherwise res_cycles is tied to 0.
module dsp_run_ctrl
    import dsp_run_pkg::*;
#(
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic        clk,
    input  logic        rst,
    dsp_run_if.slave    bus,
    output logic        core_rst,
    output logic        core_start,
    input  logic        core_done,
    input  logic [31:0] core_acc,
    input  logic [15:0] core_pc
);

    state_t          state, next_state;
    logic [PH_W-1:0] ph_cnt;
    logic            rdy_q;
    logic [TO_W-1:0] max_q;
    logic [31:0]     exp_q;
    logic            wd_clr, wd_en, wd_at_limit;
    logic [TO_W-1:0] wd_count;
    logic            cap;
    status_t         cap_status;
    status_t         status_q;
    logic [31:0]     acc_q;
    logic [15:0]     pc_q;
    logic            accept;
    logic            rst_last, gap_last;

    // A zero RST_CYC still yields one CRST cycle.
    assign rst_last = (int'(ph_cnt) + 1) >= RST_CYC;
    assign gap_last = (int'(ph_cnt) + 1) >= GAP_CYC;
    assign accept   = (state == S_IDLE) && bus.cmd_valid && rdy_q;

    dsp_run_wdog #(.TO_W(TO_W)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .en       (wd_en),
        .limit    (max_q),
        .count    (wd_count),
        .at_limit (wd_at_limit)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Abort outranks done, which outranks timeout.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state    = state;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;
        cap           = 1'b0;
        cap_status    = ST_PASS;
        core_rst      = 1'b0;
        core_start    = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            S_IDLE: begin
                core_rst      = 1'b1;
                bus.busy      = 1'b0;
                bus.cmd_ready = rdy_q;
                wd_clr        = 1'b1;
                if (accept) next_state = S_CRST;
            end
            S_CRST: begin
                core_rst = 1'b1;
                if (bus.abort) begin
                    cap = 1'b1; cap_status = ST_ABORT; next_state = S_REPORT;
                end else if (rst_last) begin
                    next_state = (GAP_CYC == 0) ? S_START : S_GAP;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    cap = 1'b1; cap_status = ST_ABORT; next_state = S_REPORT;
                end else if (gap_last) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                core_start = 1'b1;
                wd_clr     = 1'b1;
                if (bus.abort) begin
                    cap = 1'b1; cap_status = ST_ABORT; next_state = S_REPORT;
                end else begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    cap = 1'b1; cap_status = ST_ABORT; next_state = S_REPORT;
                end else if (core_done) begin
                    cap        = 1'b1;
                    cap_status = (core_acc == exp_q) ? ST_PASS : ST_FAIL;
                    next_state = S_REPORT;
                end else if (wd_at_limit) begin
                    cap = 1'b1; cap_status = ST_TIMEOUT; next_state = S_REPORT;
                end else begin
                    wd_en = 1'b1;
                end
            end
            S_REPORT: begin
                core_rst      = 1'b1;
                bus.res_valid = 1'b1;
                if (bus.res_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

`ifdef DSP_RUN_CYCLE_COUNT_EN
    logic [TO_W-1:0] cyc_q;
`endif

    // NOTE: result registers are reset explicitly because res_* must read 0
    // after reset, not merely be don't-care until the first run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q    <= 1'b0;
            ph_cnt   <= '0;
            max_q    <= '0;
            exp_q    <= '0;
            status_q <= ST_PASS;
            acc_q    <= '0;
            pc_q     <= '0;
`ifdef DSP_RUN_CYCLE_COUNT_EN
            cyc_q    <= '0;
`endif
        end else begin
            // cmd_ready is withheld until one clean edge after reset.
            rdy_q  <= 1'b1;
            ph_cnt <= (next_state != state) ? '0 : ph_cnt + 1'b1;
            if (accept) begin
                max_q <= bus.cmd_max_cyc;
                exp_q <= bus.cmd_exp_acc;
            end
            if (cap) begin
                status_q <= cap_status;
                acc_q    <= core_acc;
                pc_q     <= core_pc;
`ifdef DSP_RUN_CYCLE_COUNT_EN
                cyc_q    <= wd_count;
`endif
            end
        end
    end

    assign bus.res_status = status_q;
    assign bus.res_acc    = acc_q;
    assign bus.res_pc     = pc_q;

`ifdef DSP_RUN_CYCLE_COUNT_EN
    assign bus.res_cycles = cyc_q;
`else
    // The count only feeds the watchdog compare in this build.
    logic unused_cnt;
    assign unused_cnt     = ^wd_count;
    assign bus.res_cycles = '0;
`endif

endmodule

// File: tb/tb_dsp_run_ctrl.sv
// tb_dsp_run_ctrl -- self-checking bench for dsp_run_ctrl: a table of run
// scenarios (pass, fail, timeout, collision, backpressure, abort, zero
// limit, done outside RUN) plus hand sequences for abort in CRST and a
// mid-run reset.
module tb_dsp_run_ctrl;
    import dsp_run_pkg::*;

    localparam int RST_CYC = 10;
    localparam int GAP_CYC = 2;
    localparam int TO_W    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rst, core_start, core_done;
    logic [31:0] core_acc;
    logic [15:0] core_pc;

    int n_chk  = 0;
    int n_pass = 0;

    dsp_run_if #(.TO_W(TO_W)) bus ();

    dsp_run_ctrl #(.RST_CYC(RST_CYC), .GAP_CYC(GAP_CYC), .TO_W(TO_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .core_rst   (core_rst),
        .core_start (core_start),
        .core_done  (core_done),
        .core_acc   (core_acc),
        .core_pc    (core_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic [15:0] max;
        logic [31:0] exp;
        int          done_at;    // RUN cycle index of core_done, -1 never
        logic [31:0] acc;
        int          abort_at;   // RUN cycle index of abort, -1 never
        int          delay;      // cycles res_ready held low
        bit          done_early; // core_done high during CRST/GAP/START
        status_t     st;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [63:0] cyc_req(input logic [63:0] c);
`ifdef DSP_RUN_CYCLE_COUNT_EN
        return c;
`else
        return 64'd0 & c;
`endif
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int hi, lo, rc, cap_idx;
        string p;
        status_t st0;
        logic [31:0] acc0;
        logic [15:0] pc0;
        logic [TO_W-1:0] cyc0;
        p = $sformatf("v%0d_", idx);
        @(negedge clk);
        check({p, "cmd_ready_idle"}, bus.cmd_ready, 1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_max_cyc = v.max;
        bus.cmd_exp_acc = v.exp;
        core_done       = v.done_early;
        core_acc        = v.exp;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({p, "busy_run"}, bus.busy, 1);
        hi = 0;
        while (core_rst === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
        check({p, "crst_len"}, hi, RST_CYC);
        lo = 0;
        while (core_start !== 1'b1 && lo < 100) begin lo++; @(negedge clk); end
        check({p, "gap_len"}, lo, GAP_CYC);
        @(negedge clk);
        check({p, "start_pulse"}, core_start, 0);
        rc = 0;
        while (rc < 2000) begin
            core_done = (rc == v.done_at);
            bus.abort = (rc == v.abort_at);
            core_acc  = v.acc;
            core_pc   = 16'(rc);
            @(negedge clk);
            if (bus.res_valid === 1'b1) break;
            rc++;
        end
        core_done = 1'b0;
        bus.abort = 1'b0;
        core_acc  = 32'hDEAD_BEEF;
        core_pc   = 16'hFFFF;
        cap_idx = (v.st == ST_TIMEOUT) ? int'(v.max) :
                  (v.st == ST_ABORT)   ? v.abort_at : v.done_at;
        check({p, "res_valid"}, bus.res_valid, 1);
        check({p, "status"}, bus.res_status, v.st);
        check({p, "cycles"}, bus.res_cycles, cyc_req(64'(cap_idx)));
        if (v.st != ST_ABORT) begin
            check({p, "acc"}, bus.res_acc, v.acc);
            check({p, "pc"}, bus.res_pc, 16'(cap_idx));
        end
        check({p, "core_rst_report"}, core_rst, 1);
        check({p, "cmd_ready_report"}, bus.cmd_ready, 0);
        st0 = bus.res_status; acc0 = bus.res_acc; pc0 = bus.res_pc; cyc0 = bus.res_cycles;
        for (int i = 0; i < v.delay; i++) begin
            bus.res_ready = 1'b0;
            core_done     = 1'b1;
            @(negedge clk);
            check({p, "hold_valid"}, bus.res_valid, 1);
            check({p, "hold_fields"}, {bus.res_status, bus.res_acc, bus.res_pc, bus.res_cycles},
                  {st0, acc0, pc0, cyc0});
            check({p, "hold_cmd_ready"}, bus.cmd_ready, 0);
        end
        core_done     = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({p, "idle_after"}, {bus.res_valid, bus.busy, bus.cmd_ready, core_rst}, 4'b0011);
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        vecs[0] = '{16'd1000, 32'd30,        40, 32'd30,        -1, 0, 1'b0, ST_PASS};
        vecs[1] = '{16'd1000, 32'd30,        40, 32'd25,        -1, 0, 1'b0, ST_FAIL};
        vecs[2] = '{16'd100,  32'd30,        -1, 32'd7,         -1, 0, 1'b0, ST_TIMEOUT};
        vecs[3] = '{16'd50,   32'd30,        50, 32'd30,        -1, 0, 1'b0, ST_PASS};
        vecs[4] = '{16'd50,   32'd30,        50, 32'd31,        -1, 0, 1'b0, ST_FAIL};
        vecs[5] = '{16'd1000, 32'hCAFE_0001,  3, 32'hCAFE_0001, -1, 5, 1'b0, ST_PASS};
        vecs[6] = '{16'd1000, 32'd30,        -1, 32'd30,         7, 0, 1'b0, ST_ABORT};
        vecs[7] = '{16'd0,    32'd30,        -1, 32'd30,        -1, 0, 1'b0, ST_TIMEOUT};
        vecs[8] = '{16'd0,    32'd30,         0, 32'd30,        -1, 0, 1'b0, ST_PASS};
        vecs[9] = '{16'd5,    32'd30,        -1, 32'd30,        -1, 0, 1'b1, ST_TIMEOUT};

        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_max_cyc = '0; bus.cmd_exp_acc = '0;
        bus.abort = 1'b0; bus.res_ready = 1'b0;
        core_done = 1'b0; core_acc = '0; core_pc = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {core_rst, core_start, bus.cmd_ready, bus.res_valid, bus.busy},
              5'b10000);
        check("reset_res", {bus.res_status, bus.res_acc, bus.res_pc, bus.res_cycles}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.cmd_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Abort during CRST: reported with zero cycles.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_max_cyc = 16'd1000; bus.cmd_exp_acc = 32'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("crst_abort_valid", {bus.res_valid, core_rst}, 2'b11);
        check("crst_abort_status", bus.res_status, ST_ABORT);
        check("crst_abort_cycles", bus.res_cycles, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("crst_abort_idle", bus.busy, 0);

        // Reset pulse in the middle of RUN.
        bus.cmd_valid = 1'b1; bus.cmd_max_cyc = 16'd1000; bus.cmd_exp_acc = 32'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (core_start !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        check("mid_start_seen", core_start, 1);
        repeat (6) @(negedge clk);
        check("mid_busy", {bus.busy, core_rst}, 2'b10);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", {core_rst, core_start, bus.cmd_ready, bus.res_valid, bus.busy},
              5'b10000);
        check("mid_reset_res", {bus.res_status, bus.res_acc, bus.res_pc, bus.res_cycles}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ready_after", {bus.cmd_ready, bus.busy}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
